// File: rtl/sha256_msg_padder_pkg.sv
// sha256_msg_padder_pkg: shared states, constants and block-count helper for the SHA-256 padder.
package sha256_msg_padder_pkg;

    typedef enum logic [2:0] {IDLE, DATA, PAD, ZERO, LEN_HI, LEN_LO} pad_state_t;

    localparam int SHA_BLOCK_WORDS = 16;
    localparam int SHA_LEN_THRESH = 56;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    // A tail of 56+ bytes leaves no room for 0x80 plus the 8-byte length, so it spills a block.
    function automatic logic [31:0] determine_num_blocks(input logic [31:0] size);
        return (size >> 6) + (({26'b0, size[5:0]} < 32'(SHA_LEN_THRESH)) ? 32'd1 : 32'd2);
    endfunction

endpackage

// File: rtl/sha256_pad_mask.sv
// sha256_pad_mask: keeps the first count bytes of a big-endian word, inserts 0x80, zeroes the rest.
module sha256_pad_mask
    import sha256_msg_padder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  count,
    output logic [31:0] masked
);

    for (genvar k = 0; k < 4; k++) begin : g_byte
        assign masked[31-8*k -: 8] = (2'(k) < count) ? word[31-8*k -: 8] :
                                     (2'(k) == count) ? PAD_BYTE : 8'h00;
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: streams a byte message in as 32-bit words and emits FIPS 180-4 padded 512-bit blocks.
// Define SHA256_PAD_BYTE_SWAP_EN to accept little-endian input words.
module sha256_msg_padder
    import sha256_msg_padder_pkg::*;
#(
    parameter int MAX_BLOCKS = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] size,
    input  logic [31:0] in_word,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_block_last,
    output logic        out_msg_last,
    output logic [15:0] num_blocks,
    output logic        busy,
    output logic        err
);

    pad_state_t  state, state_d, fill_next;
    logic [19:0] w, fill_end;
    logic [31:0] size_q, in_be, masked, nb_calc, rem, gen_word;
    logic        can_load, load, gen_msg_last, start_ok, overflow;

`ifdef SHA256_PAD_BYTE_SWAP_EN
    assign in_be = {in_word[7:0], in_word[15:8], in_word[23:16], in_word[31:24]};
`else
    assign in_be = in_word;
`endif

    assign nb_calc   = determine_num_blocks(size);
    assign overflow  = nb_calc > 32'(MAX_BLOCKS);
    assign start_ok  = (state == IDLE) && start;
    assign can_load  = !out_valid || out_ready;
    assign in_ready  = (state == DATA) && can_load;
    assign rem       = size_q - {10'b0, w, 2'b00};
    // The last two words of the final block carry the length, so zero fill stops just before them.
    assign fill_end  = {num_blocks, 4'b0} - 20'd2;
    assign fill_next = (w + 20'd1 == fill_end) ? LEN_HI : ZERO;

    sha256_pad_mask u_mask (
        .word   (in_be),
        .count  (rem[1:0]),
        .masked (masked)
    );

    always_comb begin
        state_d      = state;
        load         = 1'b0;
        gen_word     = '0;
        gen_msg_last = 1'b0;
        case (state)
            IDLE: if (start_ok && !overflow) state_d = (size == '0) ? PAD : DATA;
            DATA: if (in_valid && can_load) begin
                load     = 1'b1;
                gen_word = (rem >= 32'd4) ? in_be : masked;
                state_d  = (rem > 32'd4) ? DATA : (rem == 32'd4) ? PAD : fill_next;
            end
            PAD: begin
                load     = can_load;
                gen_word = {PAD_BYTE, 24'b0};
                state_d  = can_load ? fill_next : PAD;
            end
            ZERO: begin
                load    = can_load;
                state_d = can_load ? fill_next : ZERO;
            end
            LEN_HI: begin
                load     = can_load;
                gen_word = {29'b0, size_q[31:29]};
                state_d  = can_load ? LEN_LO : LEN_HI;
            end
            LEN_LO: begin
                load         = can_load;
                gen_word     = {size_q[28:0], 3'b0};
                gen_msg_last = 1'b1;
                state_d      = can_load ? IDLE : LEN_LO;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            w              <= '0;
            size_q         <= '0;
            num_blocks     <= '0;
            busy           <= 1'b0;
            err            <= 1'b0;
            out_valid      <= 1'b0;
            out_word       <= '0;
            out_block_last <= 1'b0;
            out_msg_last   <= 1'b0;
        end else begin
            state <= state_d;
            if (start_ok) begin
                size_q     <= size;
                w          <= '0;
                err        <= overflow;
                num_blocks <= overflow ? 16'd0 : nb_calc[15:0];
                busy       <= !overflow;
            end else if (out_valid && out_ready && out_msg_last) begin
                busy <= 1'b0;
            end
            if (load) begin
                out_valid      <= 1'b1;
                out_word       <= gen_word;
                out_block_last <= (w[3:0] == 4'(SHA_BLOCK_WORDS - 1));
                out_msg_last   <= gen_msg_last;
                w              <= w + 20'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
